dti_mem_model: RTL and testbench
================================

Name: dti_mem_model

Overview:
- Parametrised, cycle-accurate unified memory responder for the RISC-V core bench.
- Serves the core's instruction-fetch channel (imem) and data channel (dmem) from one shared word array.
- Configurable wait-state latency per channel and a misalignment error counter.
- Sits beside dti_riscv_core in test benches and replaces the fixed-latency fetch-only model.

Parameters:
ADDR_WIDTH, 32, byte-address width of both channels.
DATA_WIDTH, 32, word width; fixed at 32 in this generation.
DEPTH, 4096, number of words in the array; power of two.
IMEM_LATENCY, 1, wait cycles between imem request acceptance and ack; 0..15.
DMEM_LATENCY, 2, wait cycles between dmem request acceptance and ack; 0..15.
MAX_EXTRA, 3, upper bound of random extra wait cycles (optional feature only).

Ports:
clk  input  1  single clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
imem_address  input  ADDR_WIDTH  fetch byte address.
imem_req  input  1  fetch request, level.
imem_ack  output  1  one-cycle fetch-complete pulse.
imem_data_in  output  DATA_WIDTH  fetched word; valid while imem_ack=1.
dmem_address  input  ADDR_WIDTH  data byte address.
dmem_data_out  input  DATA_WIDTH  write data from core, lane-aligned to the address.
dmem_data_size  input  2  0=byte, 1=half, 2=word, 3=treated as word.
dmem_read_req  input  1  load request, level.
dmem_write_req  input  1  store request, level.
dmem_read_ack  output  1  one-cycle load-complete pulse.
dmem_write_ack  output  1  one-cycle store-complete pulse.
dmem_data_in  output  DATA_WIDTH  loaded word; valid while dmem_read_ack=1.
err_count  output  16  saturating count of misaligned or conflicting dmem requests.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all acks 0, both data outputs 0, err_count 0, both FSMs IDLE. Array contents are not cleared.
- Reset asserted mid-transaction aborts it with no ack. No write is committed unless its ack cycle has already occurred.
- Each channel has its own FSM: IDLE -> WAIT -> ACK -> IDLE.
- IDLE: a request seen on a clock edge is accepted. Address, size and write data are latched. The wait counter loads the channel latency.
  - If latency is 0, go directly to ACK.
  - Otherwise go to WAIT.
- WAIT: decrement the counter each cycle; on the cycle it reaches 0, go to ACK.
- ACK: pulse the ack for exactly one cycle.
  - Reads sample the array in this cycle.
  - Writes commit at the end of this cycle.
  - Then return to IDLE.
- A request still high in IDLE is a new transaction. Minimum throughput is one transaction per latency+2 cycles.
- Request inputs are ignored outside IDLE. Address and data changes after acceptance have no effect.
- Word index = address[log2(DEPTH)+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH words.
- Reads always return the full aligned word. The core extracts and extends the lanes.
- Write byte enables:
  - Byte: lane address[1:0].
  - Half: lanes {address[1],0} and {address[1],1}.
  - Word: all four lanes.
- Misaligned writes (half with address[0]=1, word with address[1:0]!=0): no array write; dmem_write_ack still pulses; err_count increments.
- Misaligned reads return the aligned word and increment err_count.
- dmem_read_req and dmem_write_req both high in IDLE: handled as a write only, no read ack, and err_count increments.
- err_count saturates at 0xFFFF.
- Same-cycle imem read and dmem write commit to the same word: imem returns the old value. The write is visible from the next cycle.
- Data outputs hold their last value when the ack is 0.

Optional Feature:
- Macro: DTI_MEM_MODEL_RAND_LATENCY_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 on reset) advances every cycle. On each acceptance the channel wait count becomes latency + (lfsr[3:0] mod (MAX_EXTRA+1)). The imem channel uses lfsr[3:0] and the dmem channel uses lfsr[7:4].
- Not defined: latency is exactly IMEM_LATENCY or DMEM_LATENCY and there is no LFSR logic.

Test Plan:
1. Word write 0xDEADBEEF to 0x100, then word read 0x100 at DMEM_LATENCY=2 -> write_ack 3 cycles after write_req is sampled; read returns 0xDEADBEEF with read_ack on cycle 3; err_count=0.
2. Byte writes 0x11, 0x22, 0x33, 0x44 to 0x200..0x203 (data lane-aligned), then word read 0x200 -> 0x44332211.
3. Half write to 0x301 -> write_ack pulses, word at 0x300 unchanged, err_count=1. Read and write requests together -> write only, err_count=2.
4. imem_req held high at IMEM_LATENCY=0 from 0x0 -> imem_ack every 2nd cycle with the preloaded word of address 0x0 each time; no double ack.
5. Reset asserted during dmem WAIT of a write to 0x400 -> no ack, word at 0x400 unchanged; after reset all outputs 0 and FSMs accept on the next request.
6. Write 0x12345678 to 0x4000 with DEPTH=4096 -> read of 0x0 returns 0x12345678 (wrap). With DTI_MEM_MODEL_RAND_LATENCY_EN defined, 100 reads have ack latency within [DMEM_LATENCY+1, DMEM_LATENCY+MAX_EXTRA+1] and the data is always correct.

Source files
------------

// File: rtl/dti_mem_model.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : dti_mem_model                                                |
// | Description : Unified two-channel (imem fetch / dmem load-store) memory    |
// |               responder with per-channel wait states, byte-lane writes     |
// |               and a saturating misalignment/conflict error counter.        |
// |               Optional random extra latency: DTI_MEM_MODEL_RAND_LATENCY_EN |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dti_mem_model #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4096,
  parameter int IMEM_LATENCY = 1,
  parameter int DMEM_LATENCY = 2,
  parameter int MAX_EXTRA    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] imem_address,
  input  logic                  imem_req,
  output logic                  imem_ack,
  output logic [DATA_WIDTH-1:0] imem_data_in,
  input  logic [ADDR_WIDTH-1:0] dmem_address,
  input  logic [DATA_WIDTH-1:0] dmem_data_out,
  input  logic [1:0]            dmem_data_size,
  input  logic                  dmem_read_req,
  input  logic                  dmem_write_req,
  output logic                  dmem_read_ack,
  output logic                  dmem_write_ack,
  output logic [DATA_WIDTH-1:0] dmem_data_in,
  output logic [15:0]           err_count
);

  localparam int c_idx_w = $clog2(DEPTH);
  localparam int c_lanes = DATA_WIDTH / 8;
  // Wide enough for the largest latency (15) plus the largest extra delay.
  localparam int c_cnt_w = $clog2(16 + MAX_EXTRA + 1);
  localparam logic [c_cnt_w-1:0] c_imem_lat = c_cnt_w'(IMEM_LATENCY);
  localparam logic [c_cnt_w-1:0] c_dmem_lat = c_cnt_w'(DMEM_LATENCY);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // Shared word array; never cleared by reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // imem channel state
  state_t                istate_q, istate_d;
  logic [c_cnt_w-1:0]    icnt_q, icnt_d;
  logic [c_idx_w-1:0]    iidx_q, iidx_d;
  logic [DATA_WIDTH-1:0] ihold_q;

  // dmem channel state
  state_t                dstate_q, dstate_d;
  logic [c_cnt_w-1:0]    dcnt_q, dcnt_d;
  logic [c_idx_w-1:0]    didx_q, didx_d;
  logic [c_lanes-1:0]    dbe_q, dbe_d;
  logic [DATA_WIDTH-1:0] dwdata_q, dwdata_d;
  logic                  dwr_q, dwr_d;
  logic [15:0]           err_q, err_d;
  logic [DATA_WIDTH-1:0] dhold_q;

  logic [c_cnt_w-1:0]    w_iextra, w_dextra;
  logic [c_cnt_w-1:0]    w_iload, w_dload;
  logic                  w_dmis;
  logic [c_lanes-1:0]    w_dbe;
  logic                  w_unused;

  // Address bits outside the word index are deliberately ignored.
  assign w_unused = ^{imem_address, dmem_address};

`ifdef DTI_MEM_MODEL_RAND_LATENCY_EN
  logic [15:0] lfsr_q;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Free-running Fibonacci LFSR (taps 16,14,13,11) supplying jitter.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], w_lfsr_fb};
    end
  end

  assign w_iextra = c_cnt_w'(int'(lfsr_q[3:0]) % (MAX_EXTRA + 1));
  assign w_dextra = c_cnt_w'(int'(lfsr_q[7:4]) % (MAX_EXTRA + 1));
`else
  assign w_iextra = '0;
  assign w_dextra = '0;
`endif

  assign w_iload = c_imem_lat + w_iextra;
  assign w_dload = c_dmem_lat + w_dextra;

  // Decode dmem size into lane enables and flag misaligned accesses.
  always_comb begin
    w_dmis = 1'b0;
    w_dbe  = '0;
    unique case (dmem_data_size)
      2'd0: w_dbe = c_lanes'(1) << dmem_address[1:0];
      2'd1: begin
        w_dmis = dmem_address[0];
        w_dbe  = dmem_address[1] ? c_lanes'(4'b1100) : c_lanes'(4'b0011);
      end
      default: begin
        w_dmis = |dmem_address[1:0];
        w_dbe  = '1;
      end
    endcase
  end

  // imem FSM next state: accept, count down the wait, pulse ack.
  always_comb begin
    istate_d = istate_q;
    icnt_d   = icnt_q;
    iidx_d   = iidx_q;
    unique case (istate_q)
      S_IDLE: begin
        if (imem_req) begin
          iidx_d   = imem_address[c_idx_w+1:2];
          icnt_d   = w_iload;
          istate_d = (w_iload == '0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        icnt_d = icnt_q - c_cnt_one;
        if (icnt_q == c_cnt_one) begin
          istate_d = S_ACK;
        end
      end
      S_ACK:   istate_d = S_IDLE;
      default: istate_d = S_IDLE;
    endcase
  end

  // dmem FSM next state; a simultaneous read+write is served as a write.
  always_comb begin
    dstate_d = dstate_q;
    dcnt_d   = dcnt_q;
    didx_d   = didx_q;
    dbe_d    = dbe_q;
    dwdata_d = dwdata_q;
    dwr_d    = dwr_q;
    err_d    = err_q;
    unique case (dstate_q)
      S_IDLE: begin
        if (dmem_read_req || dmem_write_req) begin
          didx_d   = dmem_address[c_idx_w+1:2];
          dwdata_d = dmem_data_out;
          dwr_d    = dmem_write_req;
          // Misaligned writes keep all lanes disabled but still ack.
          dbe_d    = (dmem_write_req && !w_dmis) ? w_dbe : '0;
          dcnt_d   = w_dload;
          dstate_d = (w_dload == '0) ? S_ACK : S_WAIT;
          if ((w_dmis || (dmem_read_req && dmem_write_req)) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
          end
        end
      end
      S_WAIT: begin
        dcnt_d = dcnt_q - c_cnt_one;
        if (dcnt_q == c_cnt_one) begin
          dstate_d = S_ACK;
        end
      end
      S_ACK:   dstate_d = S_IDLE;
      default: dstate_d = S_IDLE;
    endcase
  end

  assign imem_ack       = (istate_q == S_ACK);
  assign dmem_read_ack  = (dstate_q == S_ACK) && !dwr_q;
  assign dmem_write_ack = (dstate_q == S_ACK) && dwr_q;
  // Reads sample the array during the ack cycle; outputs hold otherwise.
  assign imem_data_in   = imem_ack ? mem_q[iidx_q] : ihold_q;
  assign dmem_data_in   = dmem_read_ack ? mem_q[didx_q] : dhold_q;
  assign err_count      = err_q;

  // Channel state registers and held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      istate_q <= S_IDLE;
      icnt_q   <= '0;
      iidx_q   <= '0;
      ihold_q  <= '0;
      dstate_q <= S_IDLE;
      dcnt_q   <= '0;
      didx_q   <= '0;
      dbe_q    <= '0;
      dwdata_q <= '0;
      dwr_q    <= 1'b0;
      err_q    <= '0;
      dhold_q  <= '0;
    end else begin
      istate_q <= istate_d;
      icnt_q   <= icnt_d;
      iidx_q   <= iidx_d;
      dstate_q <= dstate_d;
      dcnt_q   <= dcnt_d;
      didx_q   <= didx_d;
      dbe_q    <= dbe_d;
      dwdata_q <= dwdata_d;
      dwr_q    <= dwr_d;
      err_q    <= err_d;
      if (imem_ack) begin
        ihold_q <= mem_q[iidx_q];
      end
      if (dmem_read_ack) begin
        dhold_q <= mem_q[didx_q];
      end
    end
  end

  // Write commits at the end of the ack cycle, so same-cycle reads see old data.
  always_ff @(posedge clk) begin
    if (dmem_write_ack) begin
      for (int b = 0; b < c_lanes; b++) begin
        if (dbe_q[b]) begin
          mem_q[didx_q][8*b +: 8] <= dwdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dti_mem_model.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_dti_mem_model                                             |
// | Description : Scoreboard bench for dti_mem_model: directed stimulus pushes |
// |               expected responses, a negedge monitor pops and compares.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dti_mem_model;

  localparam int ILAT = 0;
  localparam int DLAT = 2;
  localparam int MAXX = 3;
`ifdef DTI_MEM_MODEL_RAND_LATENCY_EN
  localparam int XTRA = MAXX;
`else
  localparam int XTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data_in;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_out;
  logic [1:0]  dmem_data_size;
  logic        dmem_read_req;
  logic        dmem_write_req;
  logic        dmem_read_ack;
  logic        dmem_write_ack;
  logic [31:0] dmem_data_in;
  logic [15:0] err_count;

  dti_mem_model #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .DEPTH       (4096),
    .IMEM_LATENCY(ILAT),
    .DMEM_LATENCY(DLAT),
    .MAX_EXTRA   (MAXX)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_address  (imem_address),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .imem_data_in  (imem_data_in),
    .dmem_address  (dmem_address),
    .dmem_data_out (dmem_data_out),
    .dmem_data_size(dmem_data_size),
    .dmem_read_req (dmem_read_req),
    .dmem_write_req(dmem_write_req),
    .dmem_read_ack (dmem_read_ack),
    .dmem_write_ack(dmem_write_ack),
    .dmem_data_in  (dmem_data_in),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dmem entries: absolute ack-cycle window; imem entries: gap since i_ref.
  typedef struct {
    logic [31:0] data;
    int          cmin;
    int          cmax;
  } exp_t;

  exp_t rd_q[$];
  exp_t wr_q[$];
  exp_t im_q[$];
  int   tests = 0;
  int   fails = 0;
  int   i_ref = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops its expectation and checks data and timing.
  always @(negedge clk) begin
    exp_t e;
    int   gap;
    if (dmem_read_ack) begin
      tests++;
      if (rd_q.size() == 0) begin
        fails++;
        $display("FAIL rd_ack: unexpected read ack at cycle %0d", cyc);
      end else begin
        e = rd_q.pop_front();
        if (dmem_data_in !== e.data || cyc < e.cmin || cyc > e.cmax) begin
          fails++;
          $display("FAIL rd_ack: got data %h at cycle %0d, expected %h in cycles %0d..%0d",
                   dmem_data_in, cyc, e.data, e.cmin, e.cmax);
        end
      end
    end
    if (dmem_write_ack) begin
      tests++;
      if (wr_q.size() == 0) begin
        fails++;
        $display("FAIL wr_ack: unexpected write ack at cycle %0d", cyc);
      end else begin
        e = wr_q.pop_front();
        if (cyc < e.cmin || cyc > e.cmax) begin
          fails++;
          $display("FAIL wr_ack: got cycle %0d, expected cycles %0d..%0d", cyc, e.cmin, e.cmax);
        end
      end
    end
    if (imem_ack) begin
      tests++;
      gap   = cyc - i_ref;
      i_ref = cyc;
      if (im_q.size() == 0) begin
        fails++;
        $display("FAIL im_ack: unexpected fetch ack at cycle %0d", cyc);
      end else begin
        e = im_q.pop_front();
        if (imem_data_in !== e.data || gap < e.cmin || gap > e.cmax) begin
          fails++;
          $display("FAIL im_ack: got data %h gap %0d, expected %h gap %0d..%0d",
                   imem_data_in, gap, e.data, e.cmin, e.cmax);
        end
      end
    end
  end

  task automatic wait_dack();
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (dmem_read_ack || dmem_write_ack) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL dmem_timeout: got no ack within 40 cycles, expected an ack");
      rd_q.delete();
      wr_q.delete();
    end
  endtask

  task automatic dmem_op(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic rd, input logic wr,
                         input logic [31:0] exp_rd);
    exp_t e;
    @(posedge clk);
    #1;
    dmem_address   = addr;
    dmem_data_out  = wdata;
    dmem_data_size = size;
    dmem_read_req  = rd;
    dmem_write_req = wr;
    e.data = exp_rd;
    e.cmin = cyc + DLAT + 1;
    e.cmax = cyc + DLAT + 1 + XTRA;
    if (wr) wr_q.push_back(e);
    else    rd_q.push_back(e);
    @(posedge clk);
    #1;
    dmem_read_req  = 1'b0;
    dmem_write_req = 1'b0;
    dmem_data_out  = 32'h0;
    wait_dack();
  endtask

  task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
    dmem_op(addr, data, 2'd2, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic rd_word(input logic [31:0] addr, input logic [31:0] data);
    dmem_op(addr, 32'h0, 2'd2, 1'b1, 1'b0, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] la [4];
    logic [31:0] ld [4];
    exp_t        e;
    int          cnt;

    reset          = 1'b1;
    imem_req       = 1'b0;
    imem_address   = 32'h0;
    dmem_address   = 32'h0;
    dmem_data_out  = 32'h0;
    dmem_data_size = 2'd0;
    dmem_read_req  = 1'b0;
    dmem_write_req = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_ack", {31'h0, imem_ack}, 32'h0);
    chk("rst_rd_ack", {31'h0, dmem_read_ack}, 32'h0);
    chk("rst_wr_ack", {31'h0, dmem_write_ack}, 32'h0);
    chk("rst_imem_data", imem_data_in, 32'h0);
    chk("rst_dmem_data", dmem_data_in, 32'h0);
    chk("rst_err", {16'h0, err_count}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Word write then read back
    wr_word(32'h100, 32'hDEADBEEF);
    rd_word(32'h100, 32'hDEADBEEF);
    chk("err_after_word", {16'h0, err_count}, 32'h0);

    // Byte writes with replicated data: only the addressed lane may change
    dmem_op(32'h200, 32'h11111111, 2'd0, 1'b0, 1'b1, 32'h0);
    dmem_op(32'h201, 32'h22222222, 2'd0, 1'b0, 1'b1, 32'h0);
    dmem_op(32'h202, 32'h33333333, 2'd0, 1'b0, 1'b1, 32'h0);
    dmem_op(32'h203, 32'h44444444, 2'd0, 1'b0, 1'b1, 32'h0);
    rd_word(32'h200, 32'h44332211);

    // Half and byte lane merge into an existing word
    wr_word(32'h500, 32'hA5A5A5A5);
    dmem_op(32'h502, 32'hBEEFBEEF, 2'd1, 1'b0, 1'b1, 32'h0);
    dmem_op(32'h501, 32'h77777777, 2'd0, 1'b0, 1'b1, 32'h0);
    rd_word(32'h500, 32'hBEEF77A5);

    // Misaligned half write, conflicting request, misaligned read
    wr_word(32'h300, 32'hCAFEF00D);
    dmem_op(32'h301, 32'hAAAAAAAA, 2'd1, 1'b0, 1'b1, 32'h0);
    chk("err_mis_write", {16'h0, err_count}, 32'h1);
    rd_word(32'h300, 32'hCAFEF00D);
    dmem_op(32'h300, 32'h55555555, 2'd2, 1'b1, 1'b1, 32'h0);
    chk("err_conflict", {16'h0, err_count}, 32'h2);
    rd_word(32'h300, 32'h55555555);
    dmem_op(32'h302, 32'h0, 2'd2, 1'b1, 1'b0, 32'h55555555);
    chk("err_mis_read", {16'h0, err_count}, 32'h3);

    // Address wrap: 0x4000 is word 0 when DEPTH is 4096
    wr_word(32'h4000, 32'h12345678);
    rd_word(32'h0, 32'h12345678);

    // imem request held high: four back-to-back fetches of word 0
    e.data = 32'h12345678;
    e.cmin = ILAT + 1;
    e.cmax = ILAT + 1 + XTRA;
    im_q.push_back(e);
    e.cmin = ILAT + 2;
    e.cmax = ILAT + 2 + XTRA;
    repeat (3) im_q.push_back(e);
    @(posedge clk);
    #1;
    imem_address = 32'h0;
    imem_req     = 1'b1;
    i_ref        = cyc;
    cnt          = 0;
    for (int n = 0; n < 80 && cnt < 4; n++) begin
      @(negedge clk);
      if (imem_ack) cnt++;
    end
    imem_req = 1'b0;
    chk("imem_ack_count", cnt, 32'd4);
    repeat (6) @(posedge clk);

    // Reset during the wait of a write: no ack, no commit, outputs cleared
    wr_word(32'h400, 32'h0BADF00D);
    @(posedge clk);
    #1;
    dmem_address   = 32'h400;
    dmem_data_out  = 32'hFFFFFFFF;
    dmem_data_size = 2'd2;
    dmem_write_req = 1'b1;
    @(posedge clk);
    #1;
    dmem_write_req = 1'b0;
    reset          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst2_imem_ack", {31'h0, imem_ack}, 32'h0);
    chk("rst2_wr_ack", {31'h0, dmem_write_ack}, 32'h0);
    chk("rst2_imem_data", imem_data_in, 32'h0);
    chk("rst2_dmem_data", dmem_data_in, 32'h0);
    chk("rst2_err", {16'h0, err_count}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    rd_word(32'h400, 32'h0BADF00D);
    chk("err_after_rst", {16'h0, err_count}, 32'h0);

    // Repeated reads across known words (latency window checked per read)
    la[0] = 32'h100;  ld[0] = 32'hDEADBEEF;
    la[1] = 32'h200;  ld[1] = 32'h44332211;
    la[2] = 32'h0;    ld[2] = 32'h12345678;
    la[3] = 32'h4500; ld[3] = 32'hBEEF77A5;
    for (int i = 0; i < 100; i++) begin
      rd_word(la[i % 4], ld[i % 4]);
    end

    repeat (4) @(posedge clk);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("im_q_empty", im_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
